// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word handshake between upstream and the serializer
interface bit_serializer_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end with a one-word holding register
module bit_serializer #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    bit_serializer_if.slave     up,
    output logic                ser_bit,
    output logic                ser_valid,
    output logic                ser_last,
    output logic                busy,
    output logic [15:0]         word_cnt
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] hold_reg, hold_reg_n;
    logic [DATA_W-1:0] shift_reg, shift_reg_n;
    logic              hold_v, hold_v_n;
    logic [IDX_W-1:0]  bit_idx, bit_idx_n;
    logic [15:0]       cnt_q, cnt_n;
    logic              accept;

    // s_ready comes straight from hold_v so upstream never sees a path from s_valid
    assign up.s_ready = !hold_v;
    assign accept     = up.s_valid && !hold_v;

    assign ser_valid = (state == SHIFT);
    assign ser_last  = ser_valid && (bit_idx == LAST_IDX);
    assign ser_bit   = ser_valid && (LSB_FIRST ? shift_reg[0] : shift_reg[DATA_W-1]);
    assign busy      = hold_v || ser_valid;
    assign word_cnt  = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold_reg  <= '0;
            shift_reg <= '0;
            hold_v    <= 1'b0;
            bit_idx   <= '0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            hold_reg  <= hold_reg_n;
            shift_reg <= shift_reg_n;
            hold_v    <= hold_v_n;
            bit_idx   <= bit_idx_n;
            cnt_q     <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        hold_reg_n  = hold_reg;
        shift_reg_n = shift_reg;
        hold_v_n    = hold_v;
        bit_idx_n   = bit_idx;
        cnt_n       = cnt_q;

        // Accept only happens with hold_v low, so it never collides with a reload below
        if (accept) begin
            hold_reg_n = up.s_data;
            hold_v_n   = 1'b1;
        end

        case (state)
            IDLE: begin
                if (hold_v) begin
                    shift_reg_n = hold_reg;
                    hold_v_n    = 1'b0;
                    bit_idx_n   = '0;
                    state_n     = SHIFT;
                end
            end
            SHIFT: begin
                shift_reg_n = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
                bit_idx_n   = bit_idx + 1'b1;
                if (ser_last) begin
                    cnt_n = cnt_q + 16'd1;
                    if (hold_v) begin
                        shift_reg_n = hold_reg;
                        hold_v_n    = 1'b0;
                        bit_idx_n   = '0;
                    end else begin
                        bit_idx_n = '0;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer, MSB-first and LSB-first instances
module tb_bit_serializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bit_serializer_if #(.DATA_W(W)) bus_m ();
    bit_serializer_if #(.DATA_W(W)) bus_l ();
    assign bus_l.s_valid = bus_m.s_valid;
    assign bus_l.s_data  = bus_m.s_data;

    logic        o_bit_m, o_valid_m, o_last_m, o_busy_m;
    logic        o_bit_l, o_valid_l, o_last_l, o_busy_l;
    logic [15:0] o_cnt_m, o_cnt_l;

    bit_serializer #(.DATA_W(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .up(bus_m.slave),
        .ser_bit(o_bit_m), .ser_valid(o_valid_m), .ser_last(o_last_m),
        .busy(o_busy_m), .word_cnt(o_cnt_m)
    );

    bit_serializer #(.DATA_W(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .up(bus_l.slave),
        .ser_bit(o_bit_l), .ser_valid(o_valid_l), .ser_last(o_last_l),
        .busy(o_busy_l), .word_cnt(o_cnt_l)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Timing model: a word accepted before edge k may start emitting two cycles later,
    // then occupies W contiguous cycles; words queue behind it in arrival order.
    typedef struct {
        logic [W-1:0] d;
        int           rdy;
    } word_t;

    word_t       wq[$];
    bit          act;
    int          pos;
    int          cyc = 0;
    int          xfers = 0;
    logic [15:0] mcnt;
    logic [15:0] cnt_off = 16'h0000;
    logic        e_valid, e_bit_m, e_bit_l, e_last, e_busy, e_ready;

    always @(negedge clk) begin
        if (reset) begin
            wq.delete();
            act  = 1'b0;
            pos  = 0;
            mcnt = 16'h0000;
        end else begin
            if (!act && wq.size() != 0 && wq[0].rdy <= cyc) begin
                act = 1'b1;
                pos = 0;
            end
            e_valid = act;
            e_bit_m = act ? wq[0].d[W-1-pos] : 1'b0;
            e_bit_l = act ? wq[0].d[pos] : 1'b0;
            e_last  = act && (pos == W - 1);
            e_busy  = (wq.size() != 0);
            e_ready = (wq.size() <= (act ? 1 : 0));
            chk("valid_m", o_valid_m, e_valid);
            chk("valid_l", o_valid_l, e_valid);
            chk("bit_m", o_bit_m, e_bit_m);
            chk("bit_l", o_bit_l, e_bit_l);
            chk("last_m", o_last_m, e_last);
            chk("last_l", o_last_l, e_last);
            chk("busy_m", o_busy_m, e_busy);
            chk("busy_l", o_busy_l, e_busy);
            chk("ready_m", bus_m.s_ready, e_ready);
            chk("ready_l", bus_l.s_ready, e_ready);
            chk("cnt_m", o_cnt_m, 16'(mcnt + cnt_off));
            chk("cnt_l", o_cnt_l, 16'(mcnt + cnt_off));
            if (act) begin
                pos++;
                if (pos == W) begin
                    void'(wq.pop_front());
                    act  = 1'b0;
                    mcnt = mcnt + 16'd1;
                end
            end
            if (bus_m.s_valid && e_ready) begin
                wq.push_back('{bus_m.s_data, cyc + 2});
                xfers++;
            end
        end
        cyc++;
    end

    task automatic send(input logic [W-1:0] d, input int gap);
        logic r;
        int   t;
        bus_m.s_valid = 1'b1;
        bus_m.s_data  = d;
        r = 1'b0;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            r = bus_m.s_ready;
            @(posedge clk);
            #1;
            if (r) break;
        end
        chk("xfer_done", r, 1'b1);
        bus_m.s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!o_busy_m && !o_busy_l) break;
        end
        chk("idle_reached", (t < 200) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n, output logic [31:0] sm, output logic [31:0] sl,
                           output logic [31:0] lm, output int gaps, output int first_k);
        sm = '0; sl = '0; lm = '0; gaps = 0; first_k = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_valid_m) begin
                first_k = k;
                break;
            end
        end
        if (first_k < 0) begin
            gaps = n;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(negedge clk);
                if (!o_valid_m) gaps++;
                sm = {sm[30:0], o_bit_m};
                sl = {sl[30:0], o_bit_l};
                lm = {lm[30:0], o_last_m};
            end
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic [7:0] seq_m;
        logic [7:0] seq_l;
    } vec_t;

    vec_t        vt[6];
    logic [31:0] sm, sl, lm;
    int          gaps, first_k, x0;
    logic [15:0] c0;
    logic [7:0]  w0, w1, w2;

    initial begin
        vt[0] = '{8'hB4, 8'hB4, 8'h2D};
        vt[1] = '{8'h0B, 8'h0B, 8'hD0};
        vt[2] = '{8'h01, 8'h01, 8'h80};
        vt[3] = '{8'h80, 8'h80, 8'h01};
        vt[4] = '{8'hFF, 8'hFF, 8'hFF};
        vt[5] = '{8'h6A, 8'h6A, 8'h56};

        reset = 1'b1;
        bus_m.s_valid = 1'b0;
        bus_m.s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", o_valid_m, 1'b0);
        chk("rst_ready", bus_m.s_ready, 1'b1);
        chk("rst_cnt", o_cnt_m, 16'h0000);
        @(posedge clk);
        #1;

        // Single words from idle
        for (int v = 0; v < 6; v++) begin
            wait_idle();
            c0 = o_cnt_m;
            send(vt[v].d, 0);
            collect(8, sm, sl, lm, gaps, first_k);
            chk("tbl_seq_m", sm[7:0], vt[v].seq_m);
            chk("tbl_seq_l", sl[7:0], vt[v].seq_l);
            chk("tbl_latency", first_k, 2);
            chk("tbl_gaps", gaps, 0);
            chk("tbl_last", lm[7:0], 8'h01);
            @(negedge clk);
            chk("tbl_valid_end", o_valid_m, 1'b0);
            chk("tbl_cnt", o_cnt_m, 16'(c0 + 16'd1));
            @(posedge clk);
            #1;
        end

        // Back-to-back words with s_valid held high
        wait_idle();
        fork
            begin
                send(8'h0B, 0);
                send(8'hD0, 0);
            end
            collect(16, sm, sl, lm, gaps, first_k);
        join
        chk("b2b_seq_m", sm[15:0], 16'h0BD0);
        chk("b2b_seq_l", sl[15:0], 16'hD00B);
        chk("b2b_last", lm[15:0], 16'h0101);
        chk("b2b_gaps", gaps, 0);
        @(posedge clk);
        #1;

        // Three words under continuous backpressure
        wait_idle();
        x0 = xfers;
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        fork
            begin
                send(w0, 0);
                send(w1, 0);
                send(w2, 0);
            end
            collect(24, sm, sl, lm, gaps, first_k);
        join
        chk("bp_seq_m", sm[23:0], {w0, w1, w2});
        chk("bp_gaps", gaps, 0);
        chk("bp_last", lm[23:0], 24'h010101);
        @(posedge clk);
        #1;
        wait_idle();
        chk("bp_xfers", xfers - x0, 3);

        // Random traffic against the model
        x0 = xfers;
        for (int i = 0; i < 150; i++) begin
            send(8'($urandom), $urandom_range(0, 12));
        end
        wait_idle();
        chk("rnd_xfers", xfers - x0, 150);

        // Reset mid-stream with the holding register full
        send(8'hA5, 0);
        send(8'h3C, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_valid", o_valid_m, 1'b0);
        chk("mid_rst_last", o_last_m, 1'b0);
        chk("mid_rst_ready", bus_m.s_ready, 1'b1);
        chk("mid_rst_busy", o_busy_m, 1'b0);
        chk("mid_rst_cnt", o_cnt_m, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", o_valid_l, 1'b0);
        chk("post_rst_busy", o_busy_l, 1'b0);
        @(posedge clk);
        #1;

        // Counter wrap
        send(8'h5A, 0);
        wait_idle();
        cnt_off = 16'(16'hFFFF - mcnt);
        force dut_m.cnt_q = 16'hFFFF;
        force dut_l.cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_m.cnt_q;
        release dut_l.cnt_q;
        @(negedge clk);
        chk("wrap_pre", o_cnt_m, 16'hFFFF);
        @(posedge clk);
        #1;
        send(8'hC3, 0);
        collect(8, sm, sl, lm, gaps, first_k);
        chk("wrap_seq", sm[7:0], 8'hC3);
        @(negedge clk);
        chk("wrap_cnt_m", o_cnt_m, 16'h0000);
        chk("wrap_cnt_l", o_cnt_l, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1);
    end
endmodule
